negation_seq: RTL and testbench
===============================

// Module: negation_seq
// PURPOSE
//  Multi-cycle, parametrised negation unit for the APB execution unit.
//  Processes i_argA serially, CHUNK bits per cycle, LSB first.
//  Supports three negation modes: two's complement, one's complement and sign-magnitude.
//  Flags the one two's-complement case that cannot be represented (most-negative input).
//  Uses a start/busy/done handshake so the APB wrapper can sequence it with the other ALU ops.
// PARAMETERS
//  BITS   8  operand/result width; must be >= 2
//  CHUNK  1  bits processed per cycle; must divide BITS; N = BITS/CHUNK compute cycles
// PORTS
//  i_clk     in   1      clock, rising edge
//  i_rst     in   1      reset, synchronous, active-high
//  i_start   in   1      request; sampled in IDLE or DONE only
//  i_mode    in   2      00 two's compl, 01 one's compl, 10 sign-magnitude, 11 reserved
//  i_argA    in   BITS   operand, sampled with i_start
//  o_busy    out  1      high while state == BUSY
//  o_done    out  1      one-cycle pulse, high while state == DONE
//  o_result  out  BITS   negated operand; updated only on entry to DONE, held until next DONE
//  error     out  1      status of last operation; updated with o_result
// BEHAVIOUR
//  Reset (i_rst=1 at an edge):
//   - state = IDLE; o_busy, o_done, error = 0; o_result = 0.
//   - Internal shift register, carry and chunk counter are cleared.
//   - Applies mid-operation: the operation in flight is dropped and no o_done is produced.
//  FSM: IDLE -> BUSY -> DONE -> IDLE (or DONE -> BUSY).
//  IDLE: i_start=1 at edge k captures i_argA and i_mode, sets carry = (mode==00), cnt = 0, goes to BUSY.
//  BUSY: each edge processes one CHUNK-wide slice, LSB slice first:
//   - mode 00: slice = ~a_slice + carry; carry = carry-out of the slice add (ripple across edges).
//   - mode 01: slice = ~a_slice.
//   - mode 10: slice = a_slice, except the MSB of the final slice is inverted.
//   - mode 11: slice = 0.
//   - cnt increments each edge; i_start is ignored while BUSY.
//   - The edge that processes slice N-1 (edge k+N) loads o_result and error and moves to DONE.
//  DONE: o_done = 1 for exactly one cycle.
//   - i_start=1 at edge k+N+1: accepted as in IDLE, goes straight to BUSY.
//   - Otherwise: goes to IDLE.
//  Timing:
//   - Latency: start sampled at edge k -> o_done high in the cycle after edge k+N.
//   - Throughput: one operation per N+1 cycles.
//  error rules:
//   - mode 00: error = 1 iff argA == {1'b1,{BITS-1{1'b0}}}; result is that same value (wrapped).
//   - mode 10: error = 1 iff argA == {1'b1,{BITS-1{1'b0}}} (negative zero); result = 0.
//   - mode 01: error = 0 always.
//   - mode 11: error = 1 always; result = 0.
//  Arithmetic:
//   - All arithmetic is modulo 2^BITS.
//   - The final mode-00 carry-out is discarded; it is 1 only for argA == 0, whose result is 0 with error = 0.
//  Output behaviour:
//   - o_result and error hold their last values through IDLE and BUSY.
//   - o_busy and o_done are never high together.
// TESTING
//  BITS=4, CHUNK=1: start at edge 0, argA=0001, mode=00 -> o_done after edge 4; o_result=1111, error=0.
//  BITS=4, CHUNK=1, mode=00:
//   - argA=1000 -> o_result=1000, error=1.
//   - argA=0000 -> o_result=0000, error=0.
//  BITS=4, CHUNK=1:
//   - argA=1101, mode=01 -> 0010, error=0.
//   - argA=1001, mode=10 -> 0001, error=0.
//   - argA=1000, mode=10 -> 0000, error=1.
//   - mode=11 -> 0000, error=1.
//  BITS=8, CHUNK=2: argA=0x01, mode=00 -> 0xFF, error=0, o_done after edge 4.
//   - Second start held high in the DONE cycle -> next o_done exactly 5 cycles later.
//  Mid-op events:
//   - i_start pulsed and i_argA changed during BUSY -> ignored; result matches the first operand.
//   - i_rst=1 for one edge during BUSY -> IDLE, all outputs 0, no o_done pulse.

Source files
------------

// File: rtl/negation_seq_if.sv
// Start/busy/done handshake and operand/result bus of the serial negation unit.
interface negation_seq_if #(
  parameter int unsigned BITS = 8
);
  logic            i_start;
  logic [1:0]      i_mode;
  logic [BITS-1:0] i_argA;
  logic            o_busy;
  logic            o_done;
  logic [BITS-1:0] o_result;
  logic            error;

  modport master (
    output i_start, i_mode, i_argA,
    input  o_busy, o_done, o_result, error
  );

  modport slave (
    input  i_start, i_mode, i_argA,
    output o_busy, o_done, o_result, error
  );
endinterface

// File: rtl/negation_seq.sv
// Serial negation unit: negates i_argA CHUNK bits per cycle, LSB slice first,
// in two's-complement, one's-complement or sign-magnitude mode.
module negation_seq #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned CHUNK = 1
) (
  input logic           i_clk,
  input logic           i_rst,
  negation_seq_if.slave bus
);

  localparam int unsigned N     = BITS / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [BITS-1:0]  sh;
  logic [BITS-1:0]  res_sh;
  logic [BITS-1:0]  res_next;
  logic [1:0]       mode_r;
  logic             carry;
  logic             c_out;
  logic             err_pend;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             accept;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] slice;
  logic [CHUNK-1:0] msb_mask;
  logic [CHUNK:0]   sum;
  logic             busy;
  logic             done;

  assign last   = (cnt == CNT_W'(N - 1));
  assign accept = bus.i_start && ((state == IDLE) || (state == DONE));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: start is only honoured in IDLE or DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.i_start) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    state_nx = bus.i_start ? BUSY : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (state == BUSY);
    done = (state == DONE);
  end

  assign bus.o_busy = busy;
  assign bus.o_done = done;

  // One slice of the negation; mode-00 carry ripples across cycles.
  always_comb begin
    msb_mask            = '0;
    msb_mask[CHUNK-1]   = 1'b1;
    a_slice             = sh[CHUNK-1:0];
    sum                 = {1'b0, ~a_slice} + (CHUNK+1)'(carry);
    slice               = '0;
    c_out               = 1'b0;
    case (mode_r)
      2'b00: begin
        slice = sum[CHUNK-1:0];
        c_out = sum[CHUNK];
      end
      2'b01:   slice = ~a_slice;
      2'b10:   slice = last ? (a_slice ^ msb_mask) : a_slice;
      default: slice = '0;
    endcase
    // New slice enters at the top; after N shifts the result is LSB-aligned.
    res_next = BITS'({slice, res_sh} >> CHUNK);
  end

  // Datapath: capture on accept, shift during BUSY, publish on the last slice.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh           <= '0;
      res_sh       <= '0;
      mode_r       <= '0;
      carry        <= 1'b0;
      err_pend     <= 1'b0;
      cnt          <= '0;
      bus.o_result <= '0;
      bus.error    <= 1'b0;
    end else if (accept) begin
      sh     <= bus.i_argA;
      res_sh <= '0;
      mode_r <= bus.i_mode;
      carry  <= (bus.i_mode == 2'b00);
      cnt    <= '0;
      case (bus.i_mode)
        2'b00, 2'b10: err_pend <= (bus.i_argA == MIN_NEG);
        2'b01:        err_pend <= 1'b0;
        default:      err_pend <= 1'b1;
      endcase
    end else if (state == BUSY) begin
      sh     <= sh >> CHUNK;
      res_sh <= res_next;
      carry  <= c_out;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        bus.o_result <= res_next;
        bus.error    <= err_pend;
      end
    end
  end

endmodule

// File: tb/tb_negation_seq.sv
// Scoreboard bench for negation_seq (BITS=8, CHUNK=2).
module tb_negation_seq;

  localparam int unsigned BITS  = 8;
  localparam int unsigned CHUNK = 2;
  localparam int unsigned N     = BITS / CHUNK;

  typedef struct {
    logic [BITS-1:0] res;
    logic            err;
    int unsigned     cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];

  negation_seq_if #(.BITS(BITS)) bus ();

  negation_seq #(.BITS(BITS), .CHUNK(CHUNK)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: negation rules stated directly in arithmetic terms.
  function automatic logic [BITS:0] ref_neg(input logic [BITS-1:0] a, input logic [1:0] m);
    logic [BITS-1:0] r;
    case (m)
      2'd0: begin
        r = -a;
        return {a == 8'h80, r};
      end
      2'd1: return {1'b0, ~a};
      2'd2: begin
        if (a[6:0] == 7'd0 && a[7]) return {1'b1, 8'h00};
        r = {~a[7], a[6:0]};
        return {1'b0, r};
      end
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected op.
  always @(negedge clk) begin
    if (bus.o_done) begin
      check("busy_done_exclusive", {31'd0, bus.o_busy}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done with empty scoreboard (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {24'd0, bus.o_result}, {24'd0, e.res});
        check("error", {31'd0, bus.error}, {31'd0, e.err});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge while the DUT is IDLE or DONE.
  task automatic issue(input logic [BITS-1:0] a, input logic [1:0] m);
    logic [BITS:0] r;
    exp_t e;
    r = ref_neg(a, m);
    e.res = r[BITS-1:0];
    e.err = r[BITS];
    e.cyc = cyc + 1 + N;
    sb.push_back(e);
    bus.i_start = 1'b1;
    bus.i_argA  = a;
    bus.i_mode  = m;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_argA  = BITS'($urandom);
    bus.i_mode  = 2'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.o_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done within 30 cycles (cycle %0d)", cyc);
    end
  endtask

  logic [BITS-1:0] dir_a [8] = '{8'h01, 8'h80, 8'h00, 8'hFD, 8'h81, 8'h80, 8'h5A, 8'h7F};
  logic [1:0]      dir_m [8] = '{2'd0,  2'd0,  2'd0,  2'd1,  2'd2,  2'd2,  2'd3,  2'd0};

  initial begin
    logic [BITS:0] r;
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_mode  = '0;
    bus.i_argA  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   {31'd0, bus.o_busy}, 32'd0);
    check("rst_done",   {31'd0, bus.o_done}, 32'd0);
    check("rst_result", {24'd0, bus.o_result}, 32'd0);
    check("rst_error",  {31'd0, bus.error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, each followed by an idle cycle to check hold.
    for (int i = 0; i < 8; i++) begin
      issue(dir_a[i], dir_m[i]);
      wait_done();
      @(negedge clk);
      r = ref_neg(dir_a[i], dir_m[i]);
      check("hold_result", {24'd0, bus.o_result}, {24'd0, r[BITS-1:0]});
      check("hold_busy", {31'd0, bus.o_busy}, 32'd0);
    end

    // Back-to-back: start held in the DONE cycle, next done N+1 cycles later.
    issue(8'h01, 2'd0);
    wait_done();
    issue(8'h33, 2'd2);
    wait_done();
    issue(8'h80, 2'd0);
    wait_done();
    @(negedge clk);

    // Start pulse and operand change while BUSY must be ignored.
    issue(8'h12, 2'd0);
    bus.i_start = 1'b1;
    bus.i_argA  = 8'hEE;
    bus.i_mode  = 2'd1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done();
    @(negedge clk);

    // Reset mid-operation: op dropped, outputs cleared, no done pulse.
    issue(8'h00, 2'd1);
    wait_done();
    @(negedge clk);
    issue(8'h05, 2'd0);
    void'(sb.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy",   {31'd0, bus.o_busy}, 32'd0);
    check("midrst_done",   {31'd0, bus.o_done}, 32'd0);
    check("midrst_result", {24'd0, bus.o_result}, 32'd0);
    check("midrst_error",  {31'd0, bus.error}, 32'd0);
    repeat (8) @(negedge clk);

    // Randomized operations with random gaps, including back-to-back.
    for (int i = 0; i < 40; i++) begin
      int unsigned sel;
      int unsigned gap;
      logic [BITS-1:0] a;
      sel = $urandom_range(0, 9);
      a = (sel == 0) ? 8'h80 : (sel == 1) ? 8'h00 : BITS'($urandom);
      issue(a, 2'($urandom_range(0, 3)));
      wait_done();
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
